lenet_push_ctrl: RTL

Parametrised control unit that counts accepted accumulator write beats for each output pixel and issues a valid/ready push request to the output FIFO once per pixel. It tracks column and row position across an `IMG_W` x `IMG_H` output map and signals frame completion. The depth (beats per pixel) is set per frame at run time. The block sits between a convolution/pooling datapath and its output FIFO and applies FIFO backpressure to the datapath.

---
 rtl/lenet_push_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/lenet_push_ctrl.sv
// Output-pixel push controller: counts accumulator beats per pixel, pushes one
// FIFO entry per pixel and walks the IMG_W x IMG_H output map.
module lenet_push_ctrl #(
    parameter int MAX_DEPTH = 16,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    localparam int DW = $clog2(MAX_DEPTH + 1),
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] cfg_depth,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          push_valid,
    input  logic          push_ready,
    output logic [CW-1:0] pix_col,
    output logic [RW-1:0] pix_row,
    output logic          row_end,
    output logic          frame_done,
    output logic          cfg_err,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        PUSH  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

    state_t        state;
    logic [DW-1:0] depth;
    logic [DW-1:0] beat_cnt;

    // in_ready/push_valid/busy are registered alongside the state so they are
    // pure state decodes with no path from in_valid or push_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            depth      <= DW'(1);
            beat_cnt   <= '0;
            pix_col    <= '0;
            pix_row    <= '0;
            in_ready   <= 1'b0;
            push_valid <= 1'b0;
            row_end    <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            row_end    <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                beat_cnt   <= '0;
                pix_col    <= '0;
                pix_row    <= '0;
                in_ready   <= 1'b0;
                push_valid <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (cfg_depth != '0 && cfg_depth <= DW'(MAX_DEPTH)) begin
                                depth    <= cfg_depth;
                                beat_cnt <= '0;
                                pix_col  <= '0;
                                pix_row  <= '0;
                                state    <= ACCUM;
                                in_ready <= 1'b1;
                                busy     <= 1'b1;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                    end
                    ACCUM: begin
                        if (in_valid) begin
                            if (beat_cnt == depth - DW'(1)) begin
                                beat_cnt   <= '0;
                                state      <= PUSH;
                                in_ready   <= 1'b0;
                                push_valid <= 1'b1;
                            end else begin
                                beat_cnt <= beat_cnt + DW'(1);
                            end
                        end
                    end
                    PUSH: begin
                        if (push_ready) begin
                            push_valid <= 1'b0;
                            if (pix_col == LAST_COL) begin
                                pix_col <= '0;
                                row_end <= 1'b1;
                                // Final pixel parks the row counter at 0 rather than overflowing.
                                if (pix_row == LAST_ROW) begin
                                    pix_row    <= '0;
                                    state      <= DONE;
                                    frame_done <= 1'b1;
                                end else begin
                                    pix_row  <= pix_row + RW'(1);
                                    state    <= ACCUM;
                                    in_ready <= 1'b1;
                                end
                            end else begin
                                pix_col  <= pix_col + CW'(1);
                                state    <= ACCUM;
                                in_ready <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state      <= IDLE;
                        in_ready   <= 1'b0;
                        push_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
